// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan_loader serial chain master.
package scan_pkg;

  localparam int SADDR_W              = 3;
  localparam int DEFAULT_BUFFER_SIZE  = 32;
  localparam int DEFAULT_BUFFER_WIDTH = 8;
  localparam int DEFAULT_CLKDIV       = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Select and busy cover the same span: everything between start and done.
  function automatic logic is_active(input state_e s);
    return (s == ST_SETUP) || (s == ST_LOAD) || (s == ST_SHIFT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/scan_clkgen.sv
// sclk divider: low phase first, clkdiv clk cycles per half period.
// Counter and sclk return to zero whenever the enable is low.
module scan_clkgen
  import scan_pkg::*;
#(
  parameter int clkdiv = DEFAULT_CLKDIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(clkdiv);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             last_s;

  // Half-period counter; strobes flag the edge on which sclk toggles.
  always_comb begin
    last_s = (cnt_q == CNT_W'(clkdiv - 1));
    rise   = en && last_s && !sclk_q;
    fall   = en && last_s && sclk_q;
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en) begin
      if (last_s) begin
        cnt_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        sclk_d = sclk_q;
      end
    end else begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/scan_loader.sv
// Serial scan-chain master: serialises one buffer image onto sin/sclk.
// Define SCAN_READBACK_EN to capture sout into the rd_valid/rd_data stream.
module scan_loader
  import scan_pkg::*;
#(
  parameter int buffer_size  = DEFAULT_BUFFER_SIZE,
  parameter int buffer_width = DEFAULT_BUFFER_WIDTH,
  parameter int clkdiv       = DEFAULT_CLKDIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SADDR_W-1:0]      addr,
  input  logic                    wr_valid,
  input  logic [buffer_width-1:0] wr_data,
  output logic                    wr_ready,
  output logic                    rd_valid,
  output logic [buffer_width-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    sclk,
  output logic                    sin,
  output logic                    ssel,
  output logic [SADDR_W-1:0]      saddr,
  input  logic                    sout
);
  localparam int BYTE_W = $clog2(buffer_size);
  localparam int BIT_W  = $clog2(buffer_width);
  localparam int CNT_W  = $clog2(clkdiv);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0]       byte_q, byte_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [buffer_width-1:0] shreg_q, shreg_d;
  logic                    sin_q, sin_d;
  logic [SADDR_W-1:0]      saddr_q, saddr_d;
  logic                    busy_q, busy_d, ssel_q, ssel_d;
  logic                    wr_ready_q, wr_ready_d, done_q, done_d;
  logic                    sclk_en_s, fall_s, unused_rise_s, last_bit_s;
  logic                    rd_valid_q;
  logic [buffer_width-1:0] rd_data_q;

  assign sclk_en_s  = (state_q == ST_SHIFT);
  assign last_bit_s = (bit_q == BIT_W'(buffer_width - 1));

  scan_clkgen #(.clkdiv(clkdiv)) u_clkgen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sclk_en_s),
    .sclk (sclk),
    .rise (unused_rise_s),
    .fall (fall_s)
  );

  // Transfer sequencing; outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sin_d   = sin_q;
    saddr_d = saddr_q;
    case (state_q)
      ST_IDLE: begin
        byte_d = '0;
        if (start) begin
          saddr_d = addr;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP, ST_HOLD: begin
        if (cnt_q == CNT_W'(clkdiv - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == ST_SETUP) ? ST_LOAD : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (wr_valid) begin
          shreg_d = wr_data;
          sin_d   = wr_data[buffer_width-1];
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        // Bit boundaries fall on sclk falling edges, where sin moves to the next bit.
        if (fall_s) begin
          shreg_d = {shreg_q[buffer_width-2:0], 1'b0};
          sin_d   = shreg_q[buffer_width-2];
          if (last_bit_s) begin
            bit_d = '0;
            if (byte_q == BYTE_W'(buffer_size - 1)) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              byte_d  = byte_q + BYTE_W'(1);
              state_d = ST_LOAD;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d     = is_active(state_d);
    ssel_d     = is_active(state_d);
    wr_ready_d = (state_d == ST_LOAD);
    done_d     = (state_d == ST_DONE);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      sin_q      <= 1'b0;
      saddr_q    <= '0;
      busy_q     <= 1'b0;
      ssel_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      sin_q      <= sin_d;
      saddr_q    <= saddr_d;
      busy_q     <= busy_d;
      ssel_q     <= ssel_d;
      wr_ready_q <= wr_ready_d;
      done_q     <= done_d;
    end
  end

`ifdef SCAN_READBACK_EN
  logic [buffer_width-1:0] cap_q, cap_d, rd_data_d;
  logic                    rd_valid_d;

  // sout is taken on the last clk of each high phase, i.e. the falling-edge strobe.
  always_comb begin
    cap_d      = cap_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (sclk_en_s && fall_s) begin
      cap_d = {cap_q[buffer_width-2:0], sout};
      if (last_bit_s) begin
        rd_valid_d = 1'b1;
        rd_data_d  = cap_d;
      end else begin
        rd_valid_d = 1'b0;
      end
    end else begin
      cap_d = cap_q;
    end
  end

  // Readback capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cap_q      <= cap_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
`else
  logic unused_sout_s;
  assign unused_sout_s = sout;
  assign rd_valid_q    = 1'b0;
  assign rd_data_q     = '0;
`endif

  assign sin      = sin_q;
  assign ssel     = ssel_q;
  assign saddr    = saddr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_scan_loader.sv
// Self-checking bench for scan_loader against a buffer-bank image model.
module tb_scan_loader;
  localparam int BS = 32;
  localparam int BW = 8;
  localparam int CD = 4;
  localparam int XFER_CYC = CD + BS * (1 + 2 * CD * BW) + CD + 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_valid = 1'b0, sout = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic wr_ready, rd_valid, busy, done, sclk, sin, ssel;
  logic [7:0] rd_data;
  logic [2:0] saddr;

  int tests = 0, fails = 0, cyc = 0;

  // Bank model: previous image per buffer, returned on sout during the next load.
  logic [7:0] mem [8][BS];
  logic [7:0] tx_img [BS];
  logic [7:0] rb_img [BS];
  logic [7:0] exp_rb [BS];
  int rb_base = 0;

  int rises = 0, dones = 0;
  logic prev_sclk = 1'b0;
  logic rx_bits [$];
  logic [7:0] rd_q [$];

  int b_cyc, d_cyc, stall_bad;
  logic busy0, ssel0, ssel_done, xfer_timeout;
  logic [2:0] saddr0;

  scan_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .sclk(sclk), .sin(sin), .ssel(ssel), .saddr(saddr), .sout(sout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe the serial port and play the bank's side of the chain.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk <= 1'b0;
    end else begin
      prev_sclk <= sclk;
      if (sclk && !prev_sclk) begin
        rx_bits.push_back(sin);
        rises <= rises + 1;
        if ((rises - rb_base) >= 0 && (rises - rb_base) < BS * BW)
          sout <= rb_img[(rises - rb_base) / BW][BW - 1 - ((rises - rb_base) % BW)];
      end
      if (done) dones <= dones + 1;
      if (rd_valid) rd_q.push_back(rd_data);
    end
  end

  task automatic run_xfer(input logic [2:0] a, input int stall_at, input int stall_len, input logic stray);
    int idx = 0;
    int stall = 0;
    logic seen = 1'b0;
    for (int i = 0; i < BS; i++) rb_img[i] = mem[a][i];
    rb_base = rises;
    stall_bad = 0;
    @(negedge clk);
    start = 1'b1;
    addr = a;
    @(negedge clk);
    start = 1'b0;
    addr = 3'($urandom);
    busy0 = busy; ssel0 = ssel; saddr0 = saddr; b_cyc = cyc;
    for (int t = 0; t < 20000 && !seen; t++) begin
      if (done) begin
        seen = 1'b1; d_cyc = cyc; ssel_done = ssel;
      end else begin
        start = stray && (t == 100);
        if (stray && t == 100) addr = 3'd2;
        if (idx == stall_at && wr_ready && stall < stall_len) begin
          wr_valid = 1'b0;
          stall++;
          if (sclk !== 1'b0 || ssel !== 1'b1) stall_bad++;
        end else if (idx < BS) begin
          wr_valid = 1'b1;
          wr_data = tx_img[idx];
          if (wr_ready) idx++;
        end else begin
          wr_valid = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    wr_valid = 1'b0;
    xfer_timeout = !seen;
    for (int i = 0; i < BS; i++) mem[a][i] = tx_img[i];
  endtask

  task automatic test_reset();
    int r0, d0;
    for (int a = 0; a < 8; a++)
      for (int i = 0; i < BS; i++) mem[a][i] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({sclk, sin, ssel, saddr, wr_ready, rd_valid, rd_data, busy, done} !== 18'd0) begin
      fails++;
      $display("FAIL reset_values: got %b, want all zero", {sclk, sin, ssel, saddr, wr_ready, rd_valid, rd_data, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < BS; i++) begin tx_img[i] = 8'($urandom); rb_img[i] = mem[6][i]; end
    rb_base = rises; r0 = rises; d0 = dones;
    start = 1'b1; addr = 3'd6; wr_valid = 1'b1; wr_data = tx_img[0];
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 1000 && (rises - r0) < 3; t++) @(negedge clk);
    tests++;
    if ((rises - r0) < 3) begin fails++; $display("FAIL reset_reach_shift: %0d sclk rises, want >=3", rises - r0); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sclk, sin, ssel, saddr, wr_ready, rd_valid, rd_data, busy, done} !== 18'd0) begin
      fails++;
      $display("FAIL reset_mid_shift: got %b, want all zero", {sclk, sin, ssel, saddr, wr_ready, rd_valid, rd_data, busy, done});
    end
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (dones !== d0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_no_done: done pulses %0d busy %b, want 0 and 0", dones - d0, busy);
    end
  endtask

  task automatic test_full_load();
    int r0, d0, rx0, rd0, errs;
    for (int i = 0; i < BS; i++) begin tx_img[i] = 8'(i); exp_rb[i] = mem[5][i]; end
    r0 = rises; d0 = dones; rx0 = rx_bits.size(); rd0 = rd_q.size();
    run_xfer(3'd5, -1, 0, 1'b0);
    repeat (5) @(negedge clk);
    tests++;
    if (xfer_timeout) begin fails++; $display("FAIL full_timeout: done never seen"); end
    tests++;
    if (busy0 !== 1'b1 || ssel0 !== 1'b1) begin fails++; $display("FAIL full_start_latency: busy %b ssel %b, want 1 1", busy0, ssel0); end
    tests++;
    if (saddr0 !== 3'd5 || saddr !== 3'd5) begin fails++; $display("FAIL full_saddr: got %0d/%0d, want 5", saddr0, saddr); end
    tests++;
    if (rises - r0 !== BS * BW) begin fails++; $display("FAIL full_rises: got %0d, want %0d", rises - r0, BS * BW); end
    errs = 0;
    for (int k = 0; k < BS * BW && rx0 + k < rx_bits.size(); k++)
      if (rx_bits[rx0 + k] !== tx_img[k / BW][BW - 1 - (k % BW)]) errs++;
    tests++;
    if (errs !== 0) begin fails++; $display("FAIL full_bitstream: %0d wrong bits, want 0", errs); end
    tests++;
    if (d_cyc - b_cyc + 1 !== XFER_CYC) begin fails++; $display("FAIL full_timing: got %0d cycles, want %0d", d_cyc - b_cyc + 1, XFER_CYC); end
    tests++;
    if (ssel_done !== 1'b0) begin fails++; $display("FAIL full_ssel_at_done: got %b, want 0", ssel_done); end
    tests++;
    if (dones - d0 !== 1) begin fails++; $display("FAIL full_done_count: got %0d, want 1", dones - d0); end
`ifdef SCAN_READBACK_EN
    errs = 0;
    for (int i = 0; i < BS && rd0 + i < rd_q.size(); i++) if (rd_q[rd0 + i] !== exp_rb[i]) errs++;
    tests++;
    if (rd_q.size() - rd0 !== BS || errs !== 0) begin
      fails++; $display("FAIL full_readback: %0d bytes, %0d wrong, want %0d and 0", rd_q.size() - rd0, errs, BS);
    end
`else
    tests++;
    if (rd_q.size() - rd0 !== 0 || rd_data !== 8'd0) begin
      fails++; $display("FAIL full_no_readback: %0d pulses rd_data %h, want 0 and 00", rd_q.size() - rd0, rd_data);
    end
`endif
  endtask

  task automatic test_stall();
    int rx0, rd0, errs;
    for (int i = 0; i < BS; i++) begin tx_img[i] = 8'($urandom); exp_rb[i] = mem[5][i]; end
    rx0 = rx_bits.size(); rd0 = rd_q.size();
    run_xfer(3'd5, 7, 20, 1'b0);
    repeat (3) @(negedge clk);
    tests++;
    if (xfer_timeout || d_cyc - b_cyc + 1 !== XFER_CYC + 20) begin
      fails++; $display("FAIL stall_timing: got %0d cycles (timeout %b), want %0d", d_cyc - b_cyc + 1, xfer_timeout, XFER_CYC + 20);
    end
    tests++;
    if (stall_bad !== 0) begin fails++; $display("FAIL stall_idle_port: %0d bad cycles, want 0", stall_bad); end
    errs = 0;
    for (int k = 0; k < BS * BW; k++)
      if (rx0 + k >= rx_bits.size() || rx_bits[rx0 + k] !== tx_img[k / BW][BW - 1 - (k % BW)]) errs++;
    tests++;
    if (errs !== 0) begin fails++; $display("FAIL stall_bitstream: %0d wrong bits, want 0", errs); end
`ifdef SCAN_READBACK_EN
    errs = 0;
    for (int i = 0; i < BS; i++) if (rd0 + i >= rd_q.size() || rd_q[rd0 + i] !== exp_rb[i]) errs++;
    tests++;
    if (errs !== 0) begin fails++; $display("FAIL stall_readback: %0d wrong bytes, want 0", errs); end
`endif
  endtask

  task automatic test_start_while_busy();
    int d0;
    for (int i = 0; i < BS; i++) tx_img[i] = 8'($urandom);
    d0 = dones;
    run_xfer(3'd3, -1, 0, 1'b1);
    repeat (30) @(negedge clk);
    tests++;
    if (saddr !== 3'd3) begin fails++; $display("FAIL busy_saddr: got %0d, want 3", saddr); end
    tests++;
    if (dones - d0 !== 1 || busy !== 1'b0) begin fails++; $display("FAIL busy_single_done: %0d dones busy %b, want 1 and 0", dones - d0, busy); end
    tests++;
    if (xfer_timeout || d_cyc - b_cyc + 1 !== XFER_CYC) begin
      fails++; $display("FAIL busy_timing: got %0d cycles, want %0d", d_cyc - b_cyc + 1, XFER_CYC);
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    logic [2:0] a1, a2;
    a1 = 3'($urandom);
    a2 = 3'($urandom);
    for (int i = 0; i < BS; i++) tx_img[i] = 8'($urandom);
    run_xfer(a1, -1, 0, 1'b0);
    d1 = d_cyc;
    for (int i = 0; i < BS; i++) tx_img[i] = 8'($urandom);
    run_xfer(a2, -1, 0, 1'b0);
    tests++;
    if (b_cyc - d1 - 1 !== 1) begin fails++; $display("FAIL b2b_idle_gap: busy low %0d cycles after done, want 1", b_cyc - d1 - 1); end
    tests++;
    if (saddr0 !== a2) begin fails++; $display("FAIL b2b_saddr: got %0d, want %0d", saddr0, a2); end
    tests++;
    if (xfer_timeout || d_cyc - b_cyc + 1 !== XFER_CYC) begin
      fails++; $display("FAIL b2b_timing: got %0d cycles, want %0d", d_cyc - b_cyc + 1, XFER_CYC);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_start_while_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
